// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the display pixel unpacker.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package disp_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } disp_unpk_state_e;

  // Raster position markers carried alongside each pixel.
  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } disp_marker_t;

  // Pixels per FIFO word; never less than one.
  function automatic int disp_ppw(input int word_w, input int pix_w);
    return ((word_w / pix_w) < 1) ? 1 : (word_w / pix_w);
  endfunction

  // Counter width able to hold 0..n-1; a 1-entry range still gets one bit.
  function automatic int disp_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_raster_counter.sv
// Raster x/y position counter producing sol/eol/sof/eof for the current pixel.
// Latency: markers are combinational from the count; count advances on the cycle after adv.
// Backpressure: advances only on adv (the pixel handshake), so markers hold while stalled.
module disp_raster_counter
  import disp_pkg::*;
#(
  parameter int LINE_PIX    = 1920,
  parameter int FRAME_LINES = 1080
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic adv,
  output logic sol,
  output logic eol,
  output logic sof,
  output logic eof,
  output logic frame_started
);

  localparam int XW = disp_cnt_w(LINE_PIX);
  localparam int YW = disp_cnt_w(FRAME_LINES);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Step x per handshake, wrap at line end and step y, wrap y at frame end.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) y_d = '0;
        else               y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign sol = vld & (x_q == '0);
  assign eol = vld & (x_q == X_LAST);
  assign sof = sol & (y_q == '0);
  assign eof = eol & (y_q == Y_LAST);

  // Any position other than the origin means the frame has emitted a pixel.
  assign frame_started = (x_q != '0) | (y_q != '0);

endmodule

// File: rtl/disp_pixel_unpacker.sv
// Pops line-buffer words and unpacks them LSB-first into a pixel stream with raster markers.
// Latency: 1 cycle from FIFO pop to pix_valid; word refill on last-pixel handshake is bubble-free.
// Backpressure: pix_ready low freezes pixel, markers and pops; optional DISP_UNPACK_UFLOW_CNT_EN adds underflow_cnt.
module disp_pixel_unpacker
  import disp_pkg::*;
#(
  parameter int WORD_W      = 64,
  parameter int PIX_W       = 16,
  parameter int LINE_PIX    = 1920,
  parameter int FRAME_LINES = 1080
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              underflow
`ifdef DISP_UNPACK_UFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int PPW = disp_ppw(WORD_W, PIX_W);
  localparam int IW  = disp_cnt_w(PPW);
  localparam logic [IW-1:0] IDX_LAST = IW'(PPW - 1);

  if ((WORD_W % PIX_W) != 0) begin : g_bad_width
    $error("disp_pixel_unpacker: WORD_W must be a multiple of PIX_W");
  end

  disp_unpk_state_e  state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              occ_q, occ_d;

  disp_marker_t mk;
  logic         hs;
  logic         last_pix;
  logic         pop;
  logic         frame_started;

  disp_raster_counter #(
    .LINE_PIX    (LINE_PIX),
    .FRAME_LINES (FRAME_LINES)
  ) u_raster (
    .clk           (clk),
    .rst_n         (rst_n),
    .vld           (occ_q),
    .adv           (hs),
    .sol           (mk.sol),
    .eol           (mk.eol),
    .sof           (mk.sof),
    .eof           (mk.eof),
    .frame_started (frame_started)
  );

  assign hs       = occ_q & pix_ready;
  assign last_pix = (idx_q == IDX_LAST);
  // Refill when empty, or in the same cycle the last pixel leaves, unless the frame
  // ends there: the next frame must start on a fresh word.
  assign pop      = (state_q == ACTIVE) & ~fifo_empty &
                    (~occ_q | (hs & last_pix & ~mk.eof));

  // Frame-level FSM: enable is only looked at in IDLE and at the eof handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (hs && mk.eof && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word holding register: load on pop, step the pixel index on handshake,
  // empty after the last pixel or at eof (leftover pixels are discarded).
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    occ_d  = occ_q;
    if (pop) begin
      word_d = fifo_rd_data;
      idx_d  = '0;
      occ_d  = 1'b1;
    end else if (hs) begin
      if (mk.eof || last_pix) begin
        idx_d = '0;
        occ_d = 1'b0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // State and word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      occ_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      occ_q   <= occ_d;
    end
  end

  // Select the current pixel out of the held word, lowest lane first.
  always_comb begin
    pix_data = '0;
    for (int i = 0; i < PPW; i++) begin
      if (idx_q == IW'(i)) pix_data = word_q[i*PIX_W +: PIX_W];
    end
  end

  assign fifo_rd_en = pop;
  assign pix_valid  = occ_q;
  assign pix_sol    = mk.sol;
  assign pix_eol    = mk.eol;
  assign pix_sof    = mk.sof;
  assign pix_eof    = mk.eof;

  // Starved mid-frame with the sink ready for more.
  assign underflow  = (state_q == ACTIVE) & frame_started & ~occ_q & fifo_empty & pix_ready;

`ifdef DISP_UNPACK_UFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underflow cycles.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_disp_pixel_unpacker.sv
module tb_disp_pixel_unpacker;

  localparam int LP = 4;
  localparam int FL = 2;
  localparam int NA = LP * FL;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  mk;   // {sol, eol, sof, eof}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 x 2 raster ----------------
  logic        en_a = 1'b0;
  logic        rdy_a = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_rd_data = '0;
  logic        fifo_rd_en, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, uf;
  logic [15:0] pix_data;
`ifdef DISP_UNPACK_UFLOW_CNT_EN
  logic [15:0] ucnt;
`endif

  disp_pixel_unpacker #(.WORD_W(64), .PIX_W(16), .LINE_PIX(LP), .FRAME_LINES(FL)) u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en_a),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .pix_valid    (pix_valid),
    .pix_ready    (rdy_a),
    .pix_data     (pix_data),
    .pix_sol      (pix_sol),
    .pix_eol      (pix_eol),
    .pix_sof      (pix_sof),
    .pix_eof      (pix_eof),
    .underflow    (uf)
`ifdef DISP_UNPACK_UFLOW_CNT_EN
    ,
    .underflow_cnt(ucnt)
`endif
  );

  // ---------------- DUT B: 3 x 1 raster ----------------
  logic        en_b = 1'b0;
  logic        rdy_b = 1'b1;
  logic        fifo_b_empty = 1'b1;
  logic [63:0] fifo_b_data = '0;
  logic        rd_en_b, valid_b, sol_b, eol_b, sof_b, eof_b, uf_b;
  logic [15:0] data_b;
`ifdef DISP_UNPACK_UFLOW_CNT_EN
  logic [15:0] ucnt_b;
`endif

  disp_pixel_unpacker #(.WORD_W(64), .PIX_W(16), .LINE_PIX(3), .FRAME_LINES(1)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en_b),
    .fifo_rd_en   (rd_en_b),
    .fifo_rd_data (fifo_b_data),
    .fifo_empty   (fifo_b_empty),
    .pix_valid    (valid_b),
    .pix_ready    (rdy_b),
    .pix_data     (data_b),
    .pix_sol      (sol_b),
    .pix_eol      (eol_b),
    .pix_sof      (sof_b),
    .pix_eof      (eof_b),
    .underflow    (uf_b)
`ifdef DISP_UNPACK_UFLOW_CNT_EN
    ,
    .underflow_cnt(ucnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO models (show-ahead) ----------------
  logic [63:0] fq[$];
  logic [63:0] fqb[$];
  logic [63:0] pop_tmp, pop_tmp_b;

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() != 0) pop_tmp = fq.pop_front();
    fifo_empty   <= (fq.size() == 0);
    fifo_rd_data <= (fq.size() != 0) ? fq[0] : 64'h0;
  end

  always @(posedge clk) begin
    if (rd_en_b && fqb.size() != 0) pop_tmp_b = fqb.pop_front();
    fifo_b_empty <= (fqb.size() == 0);
    fifo_b_data  <= (fqb.size() != 0) ? fqb[0] : 64'h0;
  end

  // ---------------- Reference model for DUT A ----------------
  // Each frame takes NA pixels from consecutive words; a frame that ends
  // mid-word drops the rest of that word.
  exp_t expq[$];
  int   mk_pos = 0;

  task automatic model_add(input logic [63:0] w);
    exp_t e;
    int   x, y;
    for (int j = 0; j < 4; j++) begin
      if (mk_pos < NA) begin
        x    = mk_pos % LP;
        y    = mk_pos / LP;
        e.d  = w[j*16 +: 16];
        e.mk = {x == 0, x == LP-1, (x == 0) && (y == 0), (x == LP-1) && (y == FL-1)};
        expq.push_back(e);
        mk_pos++;
      end
    end
    if (mk_pos == NA) mk_pos = 0;
  endtask

  task automatic push_a(input logic [63:0] w);
    fq.push_back(w);
    model_add(w);
  endtask

  // ---------------- Compare process (DUT A) ----------------
  int          hs_in_frame = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rd_en = 1'b0;
  logic [20:0] prev_vec = '0;
  logic [15:0] log_d[$];
  logic [3:0]  log_mk[$];
  int          log_cyc[$];
  exp_t        ce;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      hs_in_frame = 0;
      prev_stall  = 1'b0;
      prev_rd_en  = 1'b0;
    end else begin
      chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 1'b0);
      chk("underflow", uf, (hs_in_frame != 0) && !pix_valid && fifo_empty && rdy_a);
      if (prev_rd_en) chk("pop_to_valid", pix_valid, 1'b1);
      if (prev_stall)
        chk("stall_hold", {pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof}, prev_vec);
      if (!pix_valid) chk("idle_markers", {pix_sol, pix_eol, pix_sof, pix_eof}, 4'b0);
      if (fifo_rd_en) pop_cnt++;
      if (pix_valid && rdy_a) begin
        if (expq.size() == 0) begin
          chk("unexpected_pixel", pix_data, 64'hDEAD);
        end else begin
          ce = expq.pop_front();
          chk("pix_data", pix_data, ce.d);
          chk("pix_markers", {pix_sol, pix_eol, pix_sof, pix_eof}, ce.mk);
        end
        log_d.push_back(pix_data);
        log_mk.push_back({pix_sol, pix_eol, pix_sof, pix_eof});
        log_cyc.push_back(cyc);
        hs_in_frame = (hs_in_frame + 1) % NA;
      end
      prev_stall = pix_valid && !rdy_a;
      prev_rd_en = fifo_rd_en;
      prev_vec   = {pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof};
    end
  end

  // ---------------- Log / sanity process (DUT B) ----------------
  logic [15:0] logb_d[$];
  logic [3:0]  logb_mk[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_underflow", uf_b, 1'b0);
      chk("b_rd_en_while_empty", rd_en_b & fifo_b_empty, 1'b0);
      if (valid_b && rdy_b) begin
        logb_d.push_back(data_b);
        logb_mk.push_back({sol_b, eol_b, sof_b, eof_b});
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pix(input logic [15:0] v);
    int n = 0;
    while (!(pix_valid && rdy_a && pix_data == v) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_pix_timeout", n < 300, 1'b1);
  endtask

  task automatic clear_log();
    log_d.delete();
    log_mk.delete();
    log_cyc.delete();
  endtask

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h000C_000B_000A_0009;
  localparam logic [63:0] W4 = 64'h0010_000F_000E_000D;

  // Hand-derived markers {sol,eol,sof,eof} for pixels 1..8 of a 4x2 frame.
  logic [3:0] mk_lit [8] = '{4'b1010, 4'b0000, 4'b0000, 4'b0100,
                             4'b1000, 4'b0000, 4'b0000, 4'b0101};
  // Hand-derived stream for the 3x1 instance: 1,2,3 | 5,6,7 (lane 4 and 8 dropped).
  logic [15:0] b_lit_d  [6] = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7};
  logic [3:0]  b_lit_mk [6] = '{4'b1010, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b0101};

  int pop_base;
  int n;

  initial begin
    // ---- reset state ----
    #3;
    chk("rst_rd_en",  fifo_rd_en, 1'b0);
    chk("rst_valid",  pix_valid, 1'b0);
    chk("rst_data",   pix_data, 16'h0);
    chk("rst_marks",  {pix_sol, pix_eol, pix_sof, pix_eof}, 4'b0);
    chk("rst_uflow",  uf, 1'b0);
`ifdef DISP_UNPACK_UFLOW_CNT_EN
    chk("rst_ucnt",   ucnt, 16'h0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- 3x1 instance: frame end mid-word drops remaining lanes ----
    fqb.push_back(W1);
    fqb.push_back(W2);
    en_b = 1'b1;
    repeat (20) tick();
    chk("b_count", logb_d.size(), 6);
    for (int i = 0; i < 6 && i < logb_d.size(); i++) begin
      chk("b_data", logb_d[i], b_lit_d[i]);
      chk("b_marks", logb_mk[i], b_lit_mk[i]);
    end

    // ---- basic two-word frame, ready held high ----
    clear_log();
    pop_base = pop_cnt;
    push_a(W1);
    push_a(W2);
    tick();
    en_a = 1'b1;
    wait_pix(16'd8);
    repeat (3) tick();
    chk("t1_pops", pop_cnt - pop_base, 2);
    chk("t1_count", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      chk("t1_data", log_d[i], 16'(i + 1));
      chk("t1_marks", log_mk[i], mk_lit[i]);
    end
    if (log_cyc.size() == 8) chk("t1_back_to_back", log_cyc[7] - log_cyc[0], 7);

    // ---- stall on pixel 3 ----
    clear_log();
    push_a(W1);
    push_a(W2);
    wait_pix(16'd3);
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_data", pix_data, 16'h0003);
      chk("t2_hold_valid", pix_valid, 1'b1);
      chk("t2_no_pop", fifo_rd_en, 1'b0);
    end
    rdy_a = 1'b1;
    wait_pix(16'd8);
    tick();
    chk("t2_count", log_d.size(), 8);
    if (log_d.size() >= 3) chk("t2_third", log_d[2], 16'h0003);

    // ---- underflow mid-frame, then resume ----
    repeat (3) tick();
    push_a(W1);
    wait_pix(16'd4);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_uflow", uf, 1'b1);
`ifdef DISP_UNPACK_UFLOW_CNT_EN
      chk("t3_ucnt", ucnt, 16'(i));
`endif
      if (i < 2) tick();
    end
    push_a(W2);
    tick();
    chk("t3_uflow_stop", uf, 1'b0);
`ifdef DISP_UNPACK_UFLOW_CNT_EN
    chk("t3_ucnt_final", ucnt, 16'd3);
`endif
    tick();
    chk("t3_resume_data", pix_data, 16'h0005);
    chk("t3_resume_marks", {pix_valid, pix_sol, pix_sof}, 3'b110);
    wait_pix(16'd8);
    tick();

    // ---- enable drop mid-frame: finish frame then idle ----
    push_a(W1);
    push_a(W2);
    push_a(W3);
    push_a(W4);
    wait_pix(16'd2);
    en_a = 1'b0;
    wait_pix(16'd8);
    chk("t5_eof_last", pix_eof, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t5_idle_rd_en", fifo_rd_en, 1'b0);
      chk("t5_idle_valid", pix_valid, 1'b0);
      tick();
    end
    clear_log();
    en_a = 1'b1;
    wait_pix(16'd16);
    tick();
    if (log_d.size() > 0) begin
      chk("t5_next_first", log_d[0], 16'd9);
      chk("t5_next_sof", log_mk[0][1], 1'b1);
    end else begin
      chk("t5_next_count", log_d.size(), 8);
    end

    // ---- asynchronous reset mid-frame ----
    push_a(W1);
    push_a(W2);
    wait_pix(16'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rd_en", fifo_rd_en, 1'b0);
    chk("t6_valid", pix_valid, 1'b0);
    chk("t6_data", pix_data, 16'h0);
    chk("t6_marks", {pix_sol, pix_eol, pix_sof, pix_eof}, 4'b0);
    chk("t6_uflow", uf, 1'b0);
`ifdef DISP_UNPACK_UFLOW_CNT_EN
    chk("t6_ucnt", ucnt, 16'h0);
`endif
    fq.delete();
    expq.delete();
    mk_pos = 0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
    push_a(W3);
    push_a(W4);
    wait_pix(16'd9);
    chk("t6_sof_after_reset", pix_sof, 1'b1);
    wait_pix(16'd16);
    tick();

    // ---- randomized traffic ----
    for (int i = 0; i < 1500; i++) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      if (fq.size() < 4 && $urandom_range(0, 2) == 0)
        push_a({$urandom, $urandom});
      tick();
    end
    while (mk_pos != 0) push_a({$urandom, $urandom});
    rdy_a = 1'b1;
    n = 0;
    while ((expq.size() != 0 || pix_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("rand_drain", expq.size(), 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
